// File: rtl/pc_ras_unit.sv
// Y86 fetch next-PC generator with a circular return-address stack and
// sticky halt/error states.
module pc_ras_unit #(
    parameter int unsigned          DATA_WID  = 32,
    parameter logic [DATA_WID-1:0]  RESET_PC  = '0,
    parameter int unsigned          RAS_DEPTH = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                stall,
    input  logic [3:0]          icode,
    input  logic                Cnd,
    input  logic [DATA_WID-1:0] valC,
    input  logic [DATA_WID-1:0] valM,
    output logic [DATA_WID-1:0] PC,
    output logic [DATA_WID-1:0] valP,
    output logic [DATA_WID-1:0] ras_top,
    output logic                ras_hit,
    output logic                ras_empty,
    output logic                ras_full,
    output logic                halted,
    output logic                error
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_RRMOV = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OP    = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_HALTED = 2'd1,
        S_ERROR  = 2'd2
    } state_t;

    state_t                state;
    logic [2:0]            inst_len;
    logic [DATA_WID-1:0]   ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]      ras_ptr;
    logic [CNT_W-1:0]      ras_cnt;
    logic [PTR_W-1:0]      ptr_inc;
    logic [PTR_W-1:0]      ptr_dec;

    // Instruction length; invalid codes count as one byte.
    always_comb begin
        inst_len = 3'd1;
        case (icode)
            I_HALT, I_NOP, I_RET:           inst_len = 3'd1;
            I_RRMOV, I_OP, I_PUSH, I_POP:   inst_len = 3'd2;
            I_JXX, I_CALL:                  inst_len = 3'd5;
            I_IRMOV, I_RMMOV, I_MRMOV:      inst_len = 3'd6;
            default:                        inst_len = 3'd1;
        endcase
    end

    assign valP      = PC + DATA_WID'(inst_len);
    assign ras_empty = (ras_cnt == '0);
    assign ras_full  = (ras_cnt == CNT_W'(RAS_DEPTH));
    assign ras_top   = ras_empty ? '0 : ras_mem[ras_ptr];
    assign ptr_inc   = ras_ptr + PTR_W'(1);
    assign ptr_dec   = ras_ptr - PTR_W'(1);

    // ras_ptr indexes the current top entry; a push when full overwrites the oldest slot.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_RUN;
            PC      <= RESET_PC;
            ras_ptr <= '0;
            ras_cnt <= '0;
            ras_hit <= 1'b0;
            halted  <= 1'b0;
            error   <= 1'b0;
        end else if (state == S_RUN && !stall) begin
            ras_hit <= 1'b0;
            case (icode)
                I_HALT: begin
                    state  <= S_HALTED;
                    halted <= 1'b1;
                end
                I_JXX: begin
                    PC <= Cnd ? valC : valP;
                end
                I_CALL: begin
                    PC               <= valC;
                    ras_mem[ptr_inc] <= valP;
                    ras_ptr          <= ptr_inc;
                    if (!ras_full) begin
                        ras_cnt <= ras_cnt + CNT_W'(1);
                    end
                end
                I_RET: begin
                    PC      <= valM;
                    ras_hit <= !ras_empty && (ras_top == valM);
                    if (!ras_empty) begin
                        ras_ptr <= ptr_dec;
                        ras_cnt <= ras_cnt - CNT_W'(1);
                    end
                end
                I_NOP, I_RRMOV, I_IRMOV, I_RMMOV, I_MRMOV, I_OP, I_PUSH, I_POP: begin
                    PC <= valP;
                end
                default: begin
                    state <= S_ERROR;
                    error <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_ras_unit.sv
// Self-checking bench for pc_ras_unit against a queue-based reference model.
module tb_pc_ras_unit;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          stall = 1'b0;
    logic [3:0]    icode = 4'h1;
    logic          cnd = 1'b0;
    logic [DW-1:0] valc = '0;
    logic [DW-1:0] valm = '0;
    logic [DW-1:0] pc, valp, ras_top;
    logic          ras_hit, ras_empty, ras_full, halted, error;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [DW-1:0] m_pc;
    logic [DW-1:0] m_q[$];
    logic          m_hit, m_halt, m_err;

    pc_ras_unit #(.DATA_WID(DW), .RESET_PC('0), .RAS_DEPTH(DEPTH)) dut (
        .CLK(clk), .RST(rst), .stall(stall), .icode(icode), .Cnd(cnd),
        .valC(valc), .valM(valm), .PC(pc), .valP(valp), .ras_top(ras_top),
        .ras_hit(ras_hit), .ras_empty(ras_empty), .ras_full(ras_full),
        .halted(halted), .error(error)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ilen(input logic [3:0] ic);
        case (ic)
            4'h2, 4'h6, 4'hA, 4'hB: return 2;
            4'h7, 4'h8:             return 5;
            4'h3, 4'h4, 4'h5:       return 6;
            default:                return 1;
        endcase
    endfunction

    function automatic logic [DW-1:0] m_top();
        return (m_q.size() > 0) ? m_q[$] : '0;
    endfunction

    task automatic set_in(input logic r, input logic s, input logic [3:0] ic,
                          input logic c, input logic [DW-1:0] vc, input logic [DW-1:0] vm);
        rst = r; stall = s; icode = ic; cnd = c; valc = vc; valm = vm;
    endtask

    // Advance one clock and update the model from the inputs seen at that edge.
    task automatic tick();
        logic [DW-1:0] p;
        @(posedge clk);
        p = m_pc + ilen(icode);
        if (rst) begin
            m_pc = '0; m_q.delete(); m_hit = 0; m_halt = 0; m_err = 0;
        end else if (!m_halt && !m_err && !stall) begin
            m_hit = 0;
            case (icode)
                4'h0: m_halt = 1;
                4'h7: m_pc = cnd ? valc : p;
                4'h8: begin
                    m_q.push_back(p);
                    if (m_q.size() > DEPTH) void'(m_q.pop_front());
                    m_pc = valc;
                end
                4'h9: begin
                    m_hit = (m_q.size() > 0) && (m_q[$] == valm);
                    if (m_q.size() > 0) void'(m_q.pop_back());
                    m_pc = valm;
                end
                4'hC, 4'hD, 4'hE, 4'hF: m_err = 1;
                default: m_pc = p;
            endcase
        end
        #1;
    endtask

    task automatic step(input logic r, input logic s, input logic [3:0] ic,
                        input logic c, input logic [DW-1:0] vc, input logic [DW-1:0] vm);
        set_in(r, s, ic, c, vc, vm);
        tick();
    endtask

    task automatic test_reset();
        step(1, 0, 4'h1, 0, 0, 0);
        step(1, 0, 4'h1, 0, 0, 0);
        checks++; if (pc !== 32'd0) begin failures++; $display("FAIL reset_pc got=%0h exp=0", pc); end
        checks++; if (ras_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", ras_empty); end
        checks++; if (halted !== 1'b0 || error !== 1'b0) begin failures++; $display("FAIL reset_flags halted=%b error=%b exp=0/0", halted, error); end
        checks++; if (ras_hit !== 1'b0 || ras_top !== 32'd0) begin failures++; $display("FAIL reset_ras hit=%b top=%0h exp=0/0", ras_hit, ras_top); end
    endtask

    task automatic test_sequential();
        set_in(0, 0, 4'h3, 1'bx, 'x, 'x);
        #1;
        checks++; if (valp !== 32'd6) begin failures++; $display("FAIL irmov_valp got=%0h exp=6", valp); end
        tick();
        checks++; if (pc !== 32'd6) begin failures++; $display("FAIL irmov_pc got=%0h exp=6", pc); end
        set_in(0, 0, 4'h6, 1'bx, 'x, 'x);
        #1;
        checks++; if (valp !== 32'd8) begin failures++; $display("FAIL op_valp got=%0h exp=8", valp); end
        tick();
        checks++; if (pc !== 32'd8) begin failures++; $display("FAIL op_pc got=%0h exp=8", pc); end
    endtask

    task automatic test_jump();
        step(0, 0, 4'h7, 1, 64, 'x);
        checks++; if (pc !== 32'd64) begin failures++; $display("FAIL jxx_taken got=%0h exp=64", pc); end
        step(0, 0, 4'h7, 0, 80, 'x);
        checks++; if (pc !== 32'd69) begin failures++; $display("FAIL jxx_not_taken got=%0h exp=69", pc); end
    endtask

    task automatic test_call_ret();
        step(1, 0, 4'h1, 0, 0, 0);
        step(0, 0, 4'h8, 1'bx, 8, 'x);
        checks++; if (pc !== 32'd8 || ras_top !== 32'd5) begin failures++; $display("FAIL call_push pc=%0h top=%0h exp=8/5", pc, ras_top); end
        step(0, 0, 4'h9, 1'bx, 'x, 5);
        checks++; if (pc !== 32'd5 || ras_hit !== 1'b1 || ras_empty !== 1'b1) begin
            failures++; $display("FAIL ret_hit pc=%0h hit=%b empty=%b exp=5/1/1", pc, ras_hit, ras_empty); end
        step(0, 0, 4'h8, 1'bx, 8, 'x);
        step(0, 0, 4'h9, 1'bx, 'x, 16);
        checks++; if (pc !== 32'd16 || ras_hit !== 1'b0) begin failures++; $display("FAIL ret_miss pc=%0h hit=%b exp=16/0", pc, ras_hit); end
    endtask

    task automatic test_ras_overflow();
        logic [DW-1:0] t;
        step(1, 0, 4'h1, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            step(0, 0, 4'h8, 0, DW'(16 * k), 0);
            if (k >= 4) begin
                checks++; if (ras_full !== 1'b1) begin failures++; $display("FAIL ras_full_%0d got=%b exp=1", k, ras_full); end
            end
        end
        checks++; if (ras_top !== 32'd69) begin failures++; $display("FAIL ras_top_after_wrap got=%0h exp=69", ras_top); end
        for (int k = 1; k <= 5; k++) begin
            t = (k == 5) ? 32'd5 : m_top();
            step(0, 0, 4'h9, 0, 0, t);
            checks++; if (ras_hit !== (k <= 4) || pc !== t) begin
                failures++; $display("FAIL ret_%0d hit=%b pc=%0h exp=%b/%0h", k, ras_hit, pc, (k <= 4), t); end
        end
        checks++; if (ras_empty !== 1'b1) begin failures++; $display("FAIL ras_drained got=%b exp=1", ras_empty); end
    endtask

    task automatic test_stall();
        step(0, 0, 4'h8, 0, 40, 0);
        step(0, 0, 4'h9, 0, 0, 10);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 4'h8, 0, 100, 0);
            checks++; if (pc !== 32'd10 || ras_empty !== 1'b1 || ras_hit !== 1'b1) begin
                failures++; $display("FAIL stall_hold_%0d pc=%0h empty=%b hit=%b exp=a/1/1", k, pc, ras_empty, ras_hit); end
        end
        step(0, 0, 4'h8, 0, 100, 0);
        checks++; if (pc !== 32'd100 || ras_top !== 32'd15 || ras_hit !== 1'b0) begin
            failures++; $display("FAIL stall_release pc=%0h top=%0h hit=%b exp=64/f/0", pc, ras_top, ras_hit); end
    endtask

    task automatic test_sticky();
        step(0, 0, 4'h0, 0, 0, 0);
        checks++; if (halted !== 1'b1 || pc !== 32'd100) begin failures++; $display("FAIL halt pc=%0h halted=%b exp=64/1", pc, halted); end
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 4'h6, 0, 0, 0);
            checks++; if (pc !== 32'd100 || halted !== 1'b1) begin failures++; $display("FAIL halt_frozen_%0d pc=%0h halted=%b", k, pc, halted); end
        end
        step(1, 0, 4'h6, 0, 0, 0);
        checks++; if (pc !== 32'd0 || halted !== 1'b0 || ras_empty !== 1'b1) begin
            failures++; $display("FAIL halt_reset pc=%0h halted=%b empty=%b exp=0/0/1", pc, halted, ras_empty); end
        step(0, 0, 4'hE, 0, 0, 0);
        checks++; if (error !== 1'b1 || pc !== 32'd0) begin failures++; $display("FAIL err_set pc=%0h error=%b exp=0/1", pc, error); end
        step(0, 0, 4'h3, 0, 0, 0);
        checks++; if (error !== 1'b1 || pc !== 32'd0) begin failures++; $display("FAIL err_frozen pc=%0h error=%b exp=0/1", pc, error); end
        step(1, 1, 4'h1, 0, 0, 0);
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL err_reset_stall got=%b exp=0", error); end
        step(0, 0, 4'h3, 0, 0, 0);
        step(1, 1, 4'h3, 0, 0, 0);
        checks++; if (pc !== 32'd0) begin failures++; $display("FAIL reset_over_stall got=%0h exp=0", pc); end
    endtask

    task automatic test_random();
        logic [3:0] ic;
        logic r, s;
        int sel;
        for (int n = 0; n < 400; n++) begin
            r = (m_halt || m_err) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 60) == 0);
            s = ($urandom_range(0, 3) == 0);
            sel = $urandom_range(0, 99);
            if (sel < 2)      ic = 4'h0;
            else if (sel < 4) ic = 4'(12 + $urandom_range(0, 3));
            else if (sel < 24) ic = 4'h8;
            else if (sel < 44) ic = 4'h9;
            else              ic = 4'($urandom_range(1, 11));
            set_in(r, s, ic, 1'($urandom), $urandom,
                   ($urandom_range(0, 1) == 1) ? m_top() : $urandom);
            #1;
            checks++; if (valp !== m_pc + ilen(ic)) begin failures++; $display("FAIL rnd_valp n=%0d got=%0h exp=%0h", n, valp, m_pc + ilen(ic)); end
            tick();
            checks++; if (pc !== m_pc) begin failures++; $display("FAIL rnd_pc n=%0d got=%0h exp=%0h", n, pc, m_pc); end
            checks++; if (ras_top !== m_top() || ras_empty !== (m_q.size() == 0) || ras_full !== (m_q.size() == DEPTH)) begin
                failures++; $display("FAIL rnd_ras n=%0d top=%0h empty=%b full=%b exp=%0h/%b/%b", n, ras_top, ras_empty, ras_full,
                                     m_top(), (m_q.size() == 0), (m_q.size() == DEPTH)); end
            checks++; if (ras_hit !== m_hit || halted !== m_halt || error !== m_err) begin
                failures++; $display("FAIL rnd_flags n=%0d hit=%b halted=%b error=%b exp=%b/%b/%b", n, ras_hit, halted, error, m_hit, m_halt, m_err); end
        end
    endtask

    initial begin
        m_pc = '0; m_hit = 0; m_halt = 0; m_err = 0;
        test_reset();
        test_sequential();
        test_jump();
        test_call_ret();
        test_ras_overflow();
        test_stall();
        test_sticky();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
